// File: rtl/tcu_core_req_responder.sv
// Core-side responder for TCU core requests: reads CORE_REQ on interrupt, hands the
// decoded request to the core, then writes RESP and clears CORE_REQ_INT.
module tcu_core_req_responder #(
  parameter int unsigned TCU_REG_DATA_SIZE = 64,
  parameter int unsigned TCU_REG_ADDR_SIZE = 32,
  parameter int unsigned TCU_REG_BSEL_SIZE = 8,
  parameter int unsigned TCU_EP_SIZE       = 16,
  parameter int unsigned TCU_VPEID_SIZE    = 16,
  parameter int unsigned TCU_ERROR_SIZE    = 5,
  parameter int unsigned TCU_PHYSADDR_SIZE = 32,
  parameter logic [TCU_REG_ADDR_SIZE-1:0] TCU_REGADDR_CORE_REQ     = 32'h0000_0030,
  parameter logic [TCU_REG_ADDR_SIZE-1:0] TCU_REGADDR_CORE_REQ_INT = 32'h0000_0038
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         irq_i,
  output logic                         reg_en_o,
  output logic [TCU_REG_BSEL_SIZE-1:0] reg_wben_o,
  output logic [TCU_REG_ADDR_SIZE-1:0] reg_addr_o,
  output logic [TCU_REG_DATA_SIZE-1:0] reg_wdata_o,
  input  logic [TCU_REG_DATA_SIZE-1:0] reg_rdata_i,
  input  logic                         reg_stall_i,
  output logic                         req_valid_o,
  input  logic                         req_ready_i,
  output logic [2:0]                   req_type_o,
  output logic [TCU_EP_SIZE-1:0]       req_ep_o,
  output logic [TCU_VPEID_SIZE-1:0]    req_vpeid_o,
  output logic                         req_pmp_write_o,
  output logic [TCU_ERROR_SIZE-1:0]    req_pmp_error_o,
  output logic [TCU_PHYSADDR_SIZE-1:0] req_pmp_addr_o,
  input  logic                         rsp_valid_i,
  output logic                         busy_o,
  output logic [7:0]                   spurious_cnt_o
);

  localparam logic [2:0] TYPE_FORMSG  = 3'd2;
  localparam logic [2:0] TYPE_PMPFAIL = 3'd3;

  typedef enum logic [2:0] {
    IDLE, RD1, RD2, DELIVER, WAIT_RSP, WR_RSP, CLR_INT, WAIT_LOW
  } state_e;

  state_e                       state_q;
  logic [TCU_REG_DATA_SIZE-1:0] req_q;
  logic                         req_valid_q;
  logic                         busy_q;
  logic [7:0]                   spur_q;
  logic                         reg_acc;
  logic [2:0]                   rd_type;
  logic                         unused_req;

  assign reg_acc = reg_en_o & ~reg_stall_i;
  assign rd_type = reg_rdata_i[2:0];

  // Register port is a pure function of state; held steady until accepted
  always_comb begin
    reg_en_o    = 1'b0;
    reg_wben_o  = '0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    if (!reset_i) begin
      case (state_q)
        RD1: begin
          reg_en_o   = 1'b1;
          reg_addr_o = TCU_REGADDR_CORE_REQ;
        end
        WR_RSP: begin
          reg_en_o    = 1'b1;
          reg_wben_o  = '1;
          reg_addr_o  = TCU_REGADDR_CORE_REQ;
          reg_wdata_o = TCU_REG_DATA_SIZE'(1);
        end
        CLR_INT: begin
          reg_en_o   = 1'b1;
          reg_wben_o = '1;
          reg_addr_o = TCU_REGADDR_CORE_REQ_INT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      spur_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (irq_i) begin
          state_q <= RD1;
          busy_q  <= 1'b1;
        end
        RD1: if (reg_acc) state_q <= RD2;
        RD2: begin
          req_q <= reg_rdata_i;
          if (rd_type == TYPE_FORMSG || rd_type == TYPE_PMPFAIL) begin
            state_q     <= DELIVER;
            req_valid_q <= 1'b1;
          end else begin
            // Unknown request types are dropped without a RESP write
            if (spur_q != 8'hFF) spur_q <= spur_q + 8'd1;
            state_q <= CLR_INT;
          end
        end
        DELIVER: if (req_ready_i) begin
          req_valid_q <= 1'b0;
          state_q     <= WAIT_RSP;
        end
        WAIT_RSP: if (rsp_valid_i) state_q <= WR_RSP;
        WR_RSP:   if (reg_acc) state_q <= CLR_INT;
        CLR_INT:  if (reg_acc) state_q <= WAIT_LOW;
        // Wait for the interrupt level to fall so a stale level is not re-serviced
        WAIT_LOW: if (!irq_i) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_valid_o     = req_valid_q;
  assign busy_o          = busy_q;
  assign spurious_cnt_o  = spur_q;
  assign req_type_o      = req_q[2:0];
  assign req_ep_o        = req_q[TCU_EP_SIZE+2:3];
  assign req_vpeid_o     = req_q[TCU_REG_DATA_SIZE-1 -: TCU_VPEID_SIZE];
  assign req_pmp_write_o = req_q[3];
  assign req_pmp_error_o = req_q[TCU_ERROR_SIZE+3:4];
  assign req_pmp_addr_o  = req_q[TCU_REG_DATA_SIZE-1 -: TCU_PHYSADDR_SIZE];
  assign unused_req      = ^req_q;

endmodule

// File: tb/tb_tcu_core_req_responder.sv
// Scoreboard bench for tcu_core_req_responder: a TCU register model answers reads,
// a negedge monitor checks every accepted access and request against expected queues.
module tb_tcu_core_req_responder;

  logic        clk_i = 1'b0;
  logic        reset_i, irq_i, reg_en_o, reg_stall_i;
  logic [7:0]  reg_wben_o;
  logic [31:0] reg_addr_o;
  logic [63:0] reg_wdata_o, reg_rdata_i;
  logic        req_valid_o, req_ready_i, req_pmp_write_o, rsp_valid_i, busy_o;
  logic [2:0]  req_type_o;
  logic [15:0] req_ep_o, req_vpeid_o;
  logic [4:0]  req_pmp_error_o;
  logic [31:0] req_pmp_addr_o;
  logic [7:0]  spurious_cnt_o;

  always #5 clk_i = ~clk_i;

  tcu_core_req_responder dut (
    .clk_i(clk_i), .reset_i(reset_i), .irq_i(irq_i),
    .reg_en_o(reg_en_o), .reg_wben_o(reg_wben_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i), .reg_stall_i(reg_stall_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_type_o(req_type_o),
    .req_ep_o(req_ep_o), .req_vpeid_o(req_vpeid_o), .req_pmp_write_o(req_pmp_write_o),
    .req_pmp_error_o(req_pmp_error_o), .req_pmp_addr_o(req_pmp_addr_o),
    .rsp_valid_i(rsp_valid_i), .busy_o(busy_o), .spurious_cnt_o(spurious_cnt_o)
  );

  typedef struct packed {
    logic [7:0]  wben;
    logic [31:0] addr;
    logic [63:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [2:0]  rtype;
    logic [15:0] ep;
    logic [15:0] vpeid;
    logic        wr;
    logic [4:0]  err;
    logic [31:0] addr;
  } req_t;

  acc_t        exp_acc[$];
  req_t        exp_req[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_spur = 0;
  logic [63:0] core_req_val = '0;
  logic        rd_next = 1'b0;
  acc_t        mon_got, mon_exp;
  req_t        mon_rgot, mon_rexp;

  // Monitor: accesses/handshakes seen here complete at the following posedge
  always @(negedge clk_i) begin
    rd_next = 1'b0;
    if (reg_en_o === 1'b1 && reg_stall_i === 1'b0) begin
      mon_got = {reg_wben_o, reg_addr_o, reg_wdata_o};
      n_vec++;
      if (exp_acc.size() == 0) begin
        n_err++;
        $display("FAIL reg_access: got unexpected wben=%h addr=%h wdata=%h, required no access",
                 reg_wben_o, reg_addr_o, reg_wdata_o);
      end else begin
        mon_exp = exp_acc.pop_front();
        if (mon_got !== mon_exp) begin
          n_err++;
          $display("FAIL reg_access: got %h/%h/%h required %h/%h/%h", mon_got.wben,
                   mon_got.addr, mon_got.wdata, mon_exp.wben, mon_exp.addr, mon_exp.wdata);
        end
      end
      rd_next = (reg_wben_o == 8'h00);
    end
    if (req_valid_o === 1'b1 && req_ready_i === 1'b1) begin
      mon_rgot = {req_type_o, req_ep_o, req_vpeid_o, req_pmp_write_o, req_pmp_error_o,
                  req_pmp_addr_o};
      n_vec++;
      if (exp_req.size() == 0) begin
        n_err++;
        $display("FAIL req_handshake: got unexpected request %h, required none", mon_rgot);
      end else begin
        mon_rexp = exp_req.pop_front();
        if (mon_rgot !== mon_rexp) begin
          n_err++;
          $display("FAIL req_fields: got %h required %h", mon_rgot, mon_rexp);
        end
      end
    end
  end

  // TCU read data is only meaningful in the cycle after an accepted read
  always @(posedge clk_i) begin
    #1;
    reg_rdata_i = rd_next ? core_req_val : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic expect_txn(input logic [63:0] d, input bit full);
    req_t       r;
    logic [2:0] t;
    t = d[2:0];
    exp_acc.push_back({8'h00, 32'h0000_0030, 64'h0});
    if (t == 3'd2 || t == 3'd3) begin
      r.rtype = t;
      r.ep    = d[18:3];
      r.vpeid = d[63:48];
      r.wr    = d[3];
      r.err   = d[8:4];
      r.addr  = d[63:32];
      exp_req.push_back(r);
      if (full) begin
        exp_acc.push_back({8'hFF, 32'h0000_0030, 64'h1});
        exp_acc.push_back({8'hFF, 32'h0000_0038, 64'h0});
      end
    end else begin
      exp_spur = (exp_spur == 255) ? 255 : exp_spur + 1;
      exp_acc.push_back({8'hFF, 32'h0000_0038, 64'h0});
    end
  endtask

  task automatic wait_valid(output bit ok);
    for (int i = 0; i < 30 && req_valid_o !== 1'b1; i++) cyc(1);
    ok = (req_valid_o === 1'b1);
  endtask

  task automatic wait_idle(output bit ok);
    for (int i = 0; i < 30 && busy_o !== 1'b0; i++) cyc(1);
    ok = (busy_o === 1'b0);
  endtask

  task automatic wait_drained(output bit ok);
    for (int i = 0; i < 40 && exp_acc.size() != 0; i++) cyc(1);
    ok = (exp_acc.size() == 0);
  endtask

  task automatic wait_en(output bit ok);
    for (int i = 0; i < 20 && reg_en_o !== 1'b1; i++) cyc(1);
    ok = (reg_en_o === 1'b1);
  endtask

  task automatic test_reset;
    reset_i = 1'b1; irq_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0; reg_stall_i = 1'b0;
    cyc(3);
    n_vec++;
    if ({reg_en_o, reg_wben_o, reg_addr_o, reg_wdata_o, req_valid_o, req_type_o, req_ep_o,
         req_vpeid_o, req_pmp_write_o, req_pmp_error_o, req_pmp_addr_o, busy_o,
         spurious_cnt_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got en=%b valid=%b busy=%b cnt=%0d, required all zero",
               reg_en_o, req_valid_o, busy_o, spurious_cnt_o);
    end
    reset_i = 1'b0;
    cyc(3);
    n_vec++;
    if (reg_en_o !== 1'b0 || busy_o !== 1'b0 || req_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got en=%b busy=%b valid=%b, required 0/0/0",
               reg_en_o, busy_o, req_valid_o);
    end
  endtask

  task automatic test_formsg;
    bit ok;
    core_req_val = 64'h0042_0000_0000_002A;
    expect_txn(core_req_val, 1'b1);
    irq_i = 1'b1;
    cyc(2);
    n_vec++;
    if (req_valid_o !== 1'b0) begin
      n_err++; $display("FAIL formsg_early_valid: got %b required 0", req_valid_o);
    end
    cyc(1);
    n_vec++;
    if (req_valid_o !== 1'b1) begin
      n_err++; $display("FAIL formsg_latency: got valid=%b required 1 after 3 cycles", req_valid_o);
    end
    n_vec++;
    if (req_type_o !== 3'd2 || req_ep_o !== 16'd5 || req_vpeid_o !== 16'h0042 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL formsg_decode: got type=%0d ep=%0d vpeid=%h busy=%b required 2/5/0042/1",
               req_type_o, req_ep_o, req_vpeid_o, busy_o);
    end
    req_ready_i = 1'b1;
    cyc(1);
    req_ready_i = 1'b0;
    n_vec++;
    if (req_valid_o !== 1'b0) begin
      n_err++; $display("FAIL formsg_valid_drop: got %b required 0", req_valid_o);
    end
    rsp_valid_i = 1'b1;
    cyc(1);
    rsp_valid_i = 1'b0;
    wait_drained(ok);
    cyc(2);
    n_vec++;
    if (!ok || busy_o !== 1'b1 || reg_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL formsg_wait_low: got drained=%b busy=%b en=%b required 1/1/0", ok, busy_o, reg_en_o);
    end
    irq_i = 1'b0;
    wait_idle(ok);
    n_vec++;
    if (!ok || exp_req.size() != 0) begin
      n_err++;
      $display("FAIL formsg_done: got idle=%b pending_req=%0d required 1/0", ok, exp_req.size());
    end
  endtask

  task automatic test_pmpfail;
    bit ok;
    core_req_val = 64'h8000_1000_0000_003B;
    expect_txn(core_req_val, 1'b1);
    irq_i = 1'b1;
    wait_valid(ok);
    n_vec++;
    if (!ok || req_type_o !== 3'd3 || req_pmp_addr_o !== 32'h8000_1000 ||
        req_pmp_error_o !== 5'd3 || req_pmp_write_o !== 1'b1) begin
      n_err++;
      $display("FAIL pmpfail_decode: got valid=%b type=%0d addr=%h err=%0d wr=%b required 1/3/80001000/3/1",
               ok, req_type_o, req_pmp_addr_o, req_pmp_error_o, req_pmp_write_o);
    end
    req_ready_i = 1'b1;
    cyc(1);
    req_ready_i = 1'b0;
    cyc(1);
    rsp_valid_i = 1'b1;
    cyc(1);
    rsp_valid_i = 1'b0;
    wait_drained(ok);
    irq_i = 1'b0;
    wait_idle(ok);
    n_vec++;
    if (!ok || exp_acc.size() != 0 || exp_req.size() != 0) begin
      n_err++;
      $display("FAIL pmpfail_done: got idle=%b pending_acc=%0d pending_req=%0d required 1/0/0",
               ok, exp_acc.size(), exp_req.size());
    end
  endtask

  task automatic test_stall;
    bit          ok;
    logic [104:0] snap;
    core_req_val = 64'h1234_0000_0000_0132;
    expect_txn(core_req_val, 1'b1);
    reg_stall_i = 1'b1;
    irq_i = 1'b1;
    for (int ph = 0; ph < 3; ph++) begin
      if (ph == 1) begin
        wait_valid(ok);
        req_ready_i = 1'b1;
        cyc(1);
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b1;
        cyc(1);
        rsp_valid_i = 1'b0;
      end
      wait_en(ok);
      snap = {reg_en_o, reg_wben_o, reg_addr_o, reg_wdata_o};
      for (int k = 0; k < 4; k++) begin
        cyc(1);
        n_vec++;
        if (!ok || {reg_en_o, reg_wben_o, reg_addr_o, reg_wdata_o} !== snap) begin
          n_err++;
          $display("FAIL stall_hold ph%0d: got en=%b addr=%h wdata=%h required en=1 addr=%h wdata=%h",
                   ph, reg_en_o, reg_addr_o, reg_wdata_o, snap[95:64], snap[63:0]);
        end
      end
      reg_stall_i = 1'b0;
      cyc(1);
      reg_stall_i = 1'b1;
    end
    reg_stall_i = 1'b0;
    irq_i = 1'b0;
    wait_idle(ok);
    n_vec++;
    if (!ok || exp_acc.size() != 0 || exp_req.size() != 0) begin
      n_err++;
      $display("FAIL stall_done: got idle=%b pending_acc=%0d pending_req=%0d required 1/0/0",
               ok, exp_acc.size(), exp_req.size());
    end
  endtask

  task automatic test_backpressure;
    bit          ok;
    logic [72:0] snap;
    core_req_val = 64'hABCD_0000_0007_FFF2;
    expect_txn(core_req_val, 1'b1);
    irq_i = 1'b1;
    wait_valid(ok);
    snap = {req_type_o, req_ep_o, req_vpeid_o, req_pmp_write_o, req_pmp_error_o, req_pmp_addr_o};
    for (int k = 0; k < 10; k++) begin
      rsp_valid_i = (k % 2 == 0);
      cyc(1);
      n_vec++;
      if (!ok || req_valid_o !== 1'b1 ||
          {req_type_o, req_ep_o, req_vpeid_o, req_pmp_write_o, req_pmp_error_o, req_pmp_addr_o} !== snap) begin
        n_err++;
        $display("FAIL backpressure_hold cyc%0d: got valid=%b type=%0d ep=%h required valid=1 fields stable",
                 k, req_valid_o, req_type_o, req_ep_o);
      end
    end
    req_ready_i = 1'b1;
    rsp_valid_i = 1'b1;
    cyc(1);
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    cyc(3);
    n_vec++;
    if (exp_acc.size() != 2 || reg_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL handshake_rsp_ignored: got pending_acc=%0d en=%b required 2/0", exp_acc.size(), reg_en_o);
    end
    rsp_valid_i = 1'b1;
    cyc(1);
    rsp_valid_i = 1'b0;
    wait_drained(ok);
    irq_i = 1'b0;
    wait_idle(ok);
    n_vec++;
    if (!ok || exp_acc.size() != 0 || exp_req.size() != 0) begin
      n_err++;
      $display("FAIL backpressure_done: got idle=%b pending_acc=%0d required 1/0", ok, exp_acc.size());
    end
  endtask

  task automatic test_spurious;
    bit          ok;
    int          bad;
    int          tsel;
    logic [63:0] d;
    core_req_val = 64'h0;
    expect_txn(core_req_val, 1'b1);
    irq_i = 1'b1;
    wait_drained(ok);
    irq_i = 1'b0;
    wait_idle(ok);
    n_vec++;
    if (!ok || spurious_cnt_o !== 8'd1 || exp_acc.size() != 0 || req_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL spurious_first: got idle=%b cnt=%0d pending_acc=%0d required 1/1/0",
               ok, spurious_cnt_o, exp_acc.size());
    end
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      tsel = int'($urandom_range(0, 5));
      d = {$urandom, $urandom};
      d[2:0] = 3'((tsel < 2) ? tsel : tsel + 2);
      core_req_val = d;
      expect_txn(d, 1'b1);
      irq_i = 1'b1;
      wait_drained(ok);
      if (!ok) bad++;
      irq_i = 1'b0;
      wait_idle(ok);
      if (!ok) bad++;
    end
    n_vec++;
    if (bad != 0 || spurious_cnt_o !== 8'(exp_spur) || exp_spur != 255) begin
      n_err++;
      $display("FAIL spurious_saturate: got cnt=%0d timeouts=%0d required cnt=%0d timeouts=0",
               spurious_cnt_o, bad, exp_spur);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    core_req_val = 64'h0042_0000_0000_002A;
    expect_txn(core_req_val, 1'b0);
    irq_i = 1'b1;
    wait_valid(ok);
    req_ready_i = 1'b1;
    cyc(1);
    req_ready_i = 1'b0;
    cyc(2);
    expect_txn(core_req_val, 1'b1);
    reset_i = 1'b1;
    rsp_valid_i = 1'b1;
    cyc(1);
    reset_i = 1'b0;
    rsp_valid_i = 1'b0;
    exp_spur = 0;
    n_vec++;
    if ({reg_en_o, reg_wben_o, reg_addr_o, reg_wdata_o, req_valid_o, req_type_o, req_ep_o,
         req_vpeid_o, req_pmp_write_o, req_pmp_error_o, req_pmp_addr_o, busy_o,
         spurious_cnt_o} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got en=%b valid=%b busy=%b cnt=%0d type=%0d, required all zero",
               reg_en_o, req_valid_o, busy_o, spurious_cnt_o, req_type_o);
    end
    wait_valid(ok);
    n_vec++;
    if (!ok || req_type_o !== 3'd2 || req_ep_o !== 16'd5) begin
      n_err++;
      $display("FAIL reset_mid_rerun: got valid=%b type=%0d ep=%0d required 1/2/5", ok, req_type_o, req_ep_o);
    end
    req_ready_i = 1'b1;
    cyc(1);
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b1;
    cyc(1);
    rsp_valid_i = 1'b0;
    wait_drained(ok);
    irq_i = 1'b0;
    wait_idle(ok);
    n_vec++;
    if (!ok || exp_acc.size() != 0 || exp_req.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_done: got idle=%b pending_acc=%0d pending_req=%0d required 1/0/0",
               ok, exp_acc.size(), exp_req.size());
    end
  endtask

  initial begin
    test_reset;
    test_formsg;
    test_pmpfail;
    test_stall;
    test_backpressure;
    test_spurious;
    test_reset_mid;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
